// File: rtl/prvp_spi_slave_pkg.sv
// Shared constants and helpers for the single-clock SPI slave FIFO family.
package prvp_spi_slave_pkg;

    localparam int unsigned FIFO_MODE_BACKPRESSURE = 0;
    localparam int unsigned FIFO_MODE_DROP         = 1;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prvp_spi_slave_sc_fifo_if.sv
// Write/read handshake bundle between the SPI datapath, the FIFO and the bus side.
interface prvp_spi_slave_sc_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_a;
    logic                  valid_a;
    logic                  ready_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  valid_b;
    logic                  ready_b;

    modport master (
        output data_a, valid_a, ready_b,
        input  ready_a, data_b, valid_b
    );

    modport slave (
        input  data_a, valid_a, ready_b,
        output ready_a, data_b, valid_b
    );
endinterface

// File: rtl/prvp_sc_fifo_mem.sv
// FIFO storage: register array with one write port and an asynchronous read port.
module prvp_sc_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata_c
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/prvp_spi_slave_sc_fifo.sv
// Single-clock FIFO between the SPI slave datapath and the bus side, with level,
// watermark flags, flush and an optional drop-on-full mode for the unstallable SPI side.
module prvp_spi_slave_sc_fifo
    import prvp_spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUFFER_DEPTH   = 8,
    parameter int unsigned AF_THRESH      = BUFFER_DEPTH - 1,
    parameter int unsigned AE_THRESH      = 1,
    parameter int unsigned DROP_ON_FULL   = FIFO_MODE_BACKPRESSURE,
    parameter int unsigned DROP_CNT_WIDTH = 16,
    localparam int unsigned LEVEL_W       = level_w(BUFFER_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      clr_drop,
    prvp_spi_slave_sc_fifo_if.slave   bus,
    output logic [LEVEL_W-1:0]        level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int unsigned AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam logic [AW-1:0]             PTR_LAST   = AW'(BUFFER_DEPTH - 1);
    localparam logic [LEVEL_W-1:0]        LEVEL_FULL = LEVEL_W'(BUFFER_DEPTH);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = '1;

    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [LEVEL_W-1:0]        r_level;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      r_overflow;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_store;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full      = (r_level == LEVEL_FULL);
    assign bus.ready_a = !rst && ((DROP_ON_FULL == FIFO_MODE_DROP) || !w_full);
    assign bus.valid_b = (r_level != '0);
    assign w_push      = bus.valid_a && bus.ready_a;
    assign w_pop       = bus.valid_b && bus.ready_b;

    // A full FIFO only loses the word if nothing leaves in the same cycle; flush discards silently.
    assign w_drop  = (DROP_ON_FULL == FIFO_MODE_DROP) && w_push && w_full && !w_pop && !flush;
    assign w_store = w_push && !w_drop && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_store && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (w_pop && !w_store) begin
                    r_level <= r_level - 1'b1;
                end
            end
            // Clearing and dropping together leaves the new drop counted.
            if (clr_drop) begin
                r_drop_cnt <= DROP_CNT_WIDTH'(w_drop);
            end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    prvp_sc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH)
    ) u_mem (
        .clk        (clk),
        .i_we       (w_store),
        .i_waddr    (r_wr_ptr),
        .i_wdata    (bus.data_a),
        .i_raddr    (r_rd_ptr),
        .o_rdata_c  (bus.data_b)
    );

    assign level        = r_level;
    assign almost_full  = (32'(r_level) >= AF_THRESH);
    assign almost_empty = (32'(r_level) <= AE_THRESH);
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_prvp_spi_slave_sc_fifo.sv
// Bench for prvp_spi_slave_sc_fifo: three configurations driven side by side and
// compared every cycle against a queue-based reference model.
module tb_prvp_spi_slave_sc_fifo;

    localparam int N = 3;
    localparam int unsigned P_DEPTH [N] = '{8, 5, 4};
    localparam int unsigned P_AF    [N] = '{7, 3, 4};
    localparam int unsigned P_AE    [N] = '{1, 2, 0};
    localparam int unsigned P_MODE  [N] = '{0, 0, 1};
    localparam int unsigned P_DCW   [N] = '{16, 16, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] va, rb, fl, cd, rs;
    logic [31:0]  da [N];

    logic [N-1:0] o_ra, o_vb, o_af, o_ae, o_ovf;
    logic [31:0]  o_db [N];
    logic [31:0]  o_lvl [N];
    logic [31:0]  o_dc [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned LW = $clog2(P_DEPTH[g] + 1);
        localparam int unsigned DW = P_DCW[g];
        logic [LW-1:0] lvl;
        logic [DW-1:0] dc;
        logic          af, ae, ovf;

        prvp_spi_slave_sc_fifo_if #(.DATA_WIDTH(32)) bus ();

        assign bus.data_a  = da[g];
        assign bus.valid_a = va[g];
        assign bus.ready_b = rb[g];

        prvp_spi_slave_sc_fifo #(
            .DATA_WIDTH     (32),
            .BUFFER_DEPTH   (P_DEPTH[g]),
            .AF_THRESH      (P_AF[g]),
            .AE_THRESH      (P_AE[g]),
            .DROP_ON_FULL   (P_MODE[g]),
            .DROP_CNT_WIDTH (DW)
        ) u_dut (
            .clk          (clk),
            .rst          (rs[g]),
            .flush        (fl[g]),
            .clr_drop     (cd[g]),
            .bus          (bus),
            .level        (lvl),
            .almost_full  (af),
            .almost_empty (ae),
            .overflow     (ovf),
            .drop_cnt     (dc)
        );

        assign o_ra[g]  = bus.ready_a;
        assign o_vb[g]  = bus.valid_b;
        assign o_db[g]  = bus.data_b;
        assign o_lvl[g] = 32'(lvl);
        assign o_dc[g]  = 32'(dc);
        assign o_af[g]  = af;
        assign o_ae[g]  = ae;
        assign o_ovf[g] = ovf;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_q [N][$];
    int unsigned m_dc [N];
    logic        m_ovf [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the FIFO is a plain queue; outputs derive from its size.
    task automatic model_cycle();
        for (int g = 0; g < N; g++) begin
            int unsigned sz;
            logic full, e_ra, push, pop, drop;
            sz   = m_q[g].size();
            full = (sz == P_DEPTH[g]);
            e_ra = !rs[g] && ((P_MODE[g] == 1) || !full);
            check_eq($sformatf("u%0d ready_a", g), 32'(o_ra[g]), 32'(e_ra));
            check_eq($sformatf("u%0d valid_b", g), 32'(o_vb[g]), 32'(sz != 0));
            if (sz != 0) check_eq($sformatf("u%0d data_b", g), o_db[g], m_q[g][0]);
            check_eq($sformatf("u%0d level", g), o_lvl[g], sz);
            check_eq($sformatf("u%0d almost_full", g), 32'(o_af[g]), 32'(sz >= P_AF[g]));
            check_eq($sformatf("u%0d almost_empty", g), 32'(o_ae[g]), 32'(sz <= P_AE[g]));
            check_eq($sformatf("u%0d overflow", g), 32'(o_ovf[g]), 32'(m_ovf[g]));
            check_eq($sformatf("u%0d drop_cnt", g), o_dc[g], m_dc[g]);

            push = va[g] && e_ra;
            pop  = (sz != 0) && rb[g];
            if (rs[g]) begin
                m_q[g].delete();
                m_dc[g]  = 0;
                m_ovf[g] = 1'b0;
            end else begin
                drop     = !fl[g] && (P_MODE[g] == 1) && push && full && !pop;
                m_ovf[g] = drop;
                if (fl[g]) begin
                    m_q[g].delete();
                end else begin
                    if (pop) void'(m_q[g].pop_front());
                    if (push && !drop) m_q[g].push_back(da[g]);
                end
                if (cd[g]) m_dc[g] = drop ? 1 : 0;
                else if (drop && (m_dc[g] < ((32'd1 << P_DCW[g]) - 1))) m_dc[g]++;
            end
        end
    endtask

    task automatic idle();
        va = '0; rb = '0; fl = '0; cd = '0; rs = '0;
        for (int g = 0; g < N; g++) da[g] = $urandom;
    endtask

    // Inputs are set just after a falling edge; check and advance the model, then move one cycle.
    task automatic step();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic push_n(input int g, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            idle(); va[g] = 1'b1; da[g] = base + 32'(i);
            step();
        end
    endtask

    task automatic drain(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            idle(); rb[g] = 1'b1;
            step();
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            m_q[g].delete();
            m_dc[g]  = 0;
            m_ovf[g] = 1'b0;
        end
        idle();
        rs = '1;
        @(negedge clk);
        step();
        check_eq("rst ready_a held low", 32'(o_ra[0]), 32'd0);
        check_eq("rst level", o_lvl[0], 32'd0);
        check_eq("rst almost_empty", 32'(o_ae[0]), 32'd1);

        // Fill depth-8 backpressure FIFO with 0x11..0x88; the 9th offer is refused.
        for (int i = 0; i < 9; i++) begin
            idle(); va[0] = 1'b1; da[0] = 32'(32'h11 * (i + 1));
            step();
        end
        check_eq("u0 full level", o_lvl[0], 32'd8);
        check_eq("u0 full almost_full", 32'(o_af[0]), 32'd1);
        check_eq("u0 full ready_a", 32'(o_ra[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("u0 drain order", o_db[0], 32'(32'h11 * (i + 1)));
            idle(); rb[0] = 1'b1;
            step();
        end
        check_eq("u0 drained level", o_lvl[0], 32'd0);
        check_eq("u0 drained almost_empty", 32'(o_ae[0]), 32'd1);

        // Depth-5 wrap: keep two words in flight across several pointer wraps.
        push_n(1, 2, 32'hA0);
        for (int i = 0; i < 10; i++) begin
            idle(); va[1] = 1'b1; rb[1] = 1'b1; da[1] = 32'hA2 + 32'(i);
            step();
            check_eq("u1 wrap level", o_lvl[1], 32'd2);
        end
        drain(1, 3);

        // Push+pop at level 3 holds level; at full the push is refused.
        push_n(0, 3, 32'h300);
        idle(); va[0] = 1'b1; rb[0] = 1'b1; da[0] = 32'h3FF;
        step();
        check_eq("u0 push+pop level 3", o_lvl[0], 32'd3);
        push_n(0, 5, 32'h400);
        check_eq("u0 refill full", o_lvl[0], 32'd8);
        idle(); va[0] = 1'b1; rb[0] = 1'b1; da[0] = 32'h4FF;
        step();
        check_eq("u0 full push+pop level", o_lvl[0], 32'd7);
        drain(0, 8);

        // Drop mode, depth 4: two of six words lost while nothing drains.
        push_n(2, 6, 32'hC0);
        check_eq("u2 drop_cnt after 6", o_dc[2], 32'd2);
        check_eq("u2 head word", o_db[2], 32'hC0);
        idle(); va[2] = 1'b1; rb[2] = 1'b1; da[2] = 32'hC8;
        step();
        check_eq("u2 full push+pop no drop", o_dc[2], 32'd2);
        idle(); va[2] = 1'b1; cd[2] = 1'b1; da[2] = 32'hC9;
        step();
        check_eq("u2 clr with drop", o_dc[2], 32'd1);
        push_n(2, 5, 32'hD0);
        check_eq("u2 drop_cnt saturates", o_dc[2], 32'd3);

        // Flush with concurrent push and pop wins over both.
        push_n(0, 5, 32'h500);
        idle(); va[0] = 1'b1; rb[0] = 1'b1; fl[0] = 1'b1; va[2] = 1'b1; fl[2] = 1'b1;
        step();
        check_eq("u0 flush level", o_lvl[0], 32'd0);
        check_eq("u0 flush valid_b", 32'(o_vb[0]), 32'd0);
        check_eq("u2 flush keeps drop_cnt", o_dc[2], 32'd3);

        // Reset mid-stream abandons the contents.
        push_n(0, 6, 32'h600);
        idle(); rs[0] = 1'b1; va[0] = 1'b1; rb[0] = 1'b1;
        step();
        check_eq("u0 rst level", o_lvl[0], 32'd0);
        check_eq("u0 rst valid_b", 32'(o_vb[0]), 32'd0);
        check_eq("u0 ready_a during rst", 32'(o_ra[0]), 32'd0);
        idle();
        step();
        check_eq("u0 ready_a after rst", 32'(o_ra[0]), 32'd1);
        idle(); va[0] = 1'b1; da[0] = 32'h5A;
        step();
        check_eq("u0 fresh push visible", 32'(o_vb[0]), 32'd1);
        check_eq("u0 fresh push data", o_db[0], 32'h5A);

        // Random traffic on all three configurations.
        for (int c = 0; c < 2500; c++) begin
            for (int g = 0; g < N; g++) begin
                va[g] = ($urandom_range(0, 9) < 7);
                rb[g] = ($urandom_range(0, 9) < ((g == 2) ? 4 : 6));
                fl[g] = ($urandom_range(0, 59) == 0);
                cd[g] = ($urandom_range(0, 79) == 0);
                rs[g] = ($urandom_range(0, 149) == 0);
                da[g] = $urandom;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
